// File: rtl/mdu_pkg.sv
// Shared opcodes, default latencies and FSM encoding for the multiply/divide unit.
package mdu_pkg;

    // MDUop encodings, shared with the hazard unit and the main controller
    localparam logic [3:0] MDU_NONE  = 4'b0000;
    localparam logic [3:0] MDU_MULT  = 4'b0001;
    localparam logic [3:0] MDU_MULTU = 4'b0010;
    localparam logic [3:0] MDU_DIV   = 4'b0011;
    localparam logic [3:0] MDU_DIVU  = 4'b0100;
    localparam logic [3:0] MDU_MTHI  = 4'b0101;
    localparam logic [3:0] MDU_MTLO  = 4'b0110;
    localparam logic [3:0] MDU_MFHI  = 4'b0111;
    localparam logic [3:0] MDU_MFLO  = 4'b1000;

    // Default busy latencies; the down-counter is 4 bits, so both must stay within 1..15
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // True for the four opcodes that a start pulse may launch
    function automatic logic is_launch_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator: product for mult/multu, {remainder, quotient} for div/divu.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        q_neg;
    logic        r_neg;

    // Both products are formed at full 64-bit width so no high bits are lost
    assign prod_s = $signed({{32{srca[31]}}, srca}) * $signed({{32{srcb[31]}}, srcb});
    assign prod_u = {32'd0, srca} * {32'd0, srcb};

    // Signed division is done on magnitudes and the signs are reapplied afterwards.
    // This gives truncation toward zero with the remainder following the dividend, and
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    assign signed_div = (op == MDU_DIV);
    assign a_mag      = (signed_div && srca[31]) ? (32'd0 - srca) : srca;
    assign b_mag      = (signed_div && srcb[31]) ? (32'd0 - srcb) : srcb;
    // A zero divisor is replaced so the divider never sees it; the result is discarded anyway
    assign divisor    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / divisor;
    assign r_mag      = a_mag % divisor;
    assign q_neg      = signed_div && (srca[31] ^ srcb[31]);
    assign r_neg      = signed_div && srca[31];

    // Select the result pair for the requested operation
    always_comb begin
        hi          = 32'd0;
        lo          = 32'd0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT:  {hi, lo} = prod_s;
            MDU_MULTU: {hi, lo} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                lo          = q_neg ? (32'd0 - q_mag) : q_mag;
                hi          = r_neg ? (32'd0 - r_mag) : r_mag;
                div_by_zero = (srcb == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, mthi/mtlo writes and mfhi/mflo reads.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SRCA,
    input  logic [31:0] SRCB,
    input  logic [3:0]  MDUop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] MDUresult,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_dz_q, pend_dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_dz;

    // The result is computed from the live operands and captured at start,
    // so operand changes during RUN cannot disturb it
    mdu_calc u_calc (
        .op          (MDUop),
        .srca        (SRCA),
        .srcb        (SRCB),
        .hi          (calc_hi),
        .lo          (calc_lo),
        .div_by_zero (calc_dz)
    );

    // Next-state logic: launch, countdown/commit, and mthi/mtlo writes when idle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start && is_launch_op(MDUop)) begin
                    op_d      = MDUop;
                    pend_hi_d = calc_hi;
                    pend_lo_d = calc_lo;
                    pend_dz_d = calc_dz;
                    cnt_d     = is_div_op(MDUop) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_d   = RUN;
                end else if (MDUop == MDU_MTHI) begin
                    hi_d = SRCA;
                end else if (MDUop == MDU_MTLO) begin
                    lo_d = SRCA;
                end
            end
            RUN: begin
                // start/mthi/mtlo are deliberately not looked at here
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                    // A divide by zero burns its latency but leaves HI/LO alone
                    if (!(is_div_op(op_q) && pend_dz_q)) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op_q      <= MDU_NONE;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Read mux: a pure combinational view of HI/LO, not gated by busy
    always_comb begin
        MDUresult = 32'd0;
        if (MDUop == MDU_MFHI) begin
            MDUresult = hi_q;
        end else if (MDUop == MDU_MFLO) begin
            MDUresult = lo_q;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with an expected-result scoreboard.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] SRCA;
    logic [31:0] SRCB;
    logic [3:0]  MDUop;
    logic        start;
    logic        busy;
    logic [31:0] MDUresult;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .SRCA      (SRCA),
        .SRCB      (SRCB),
        .MDUop     (MDUop),
        .start     (start),
        .busy      (busy),
        .MDUresult (MDUresult),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
            $display("check %-24s got %08h expected %08h ok", tag, got, exp);
        end else begin
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Count busy cycles after a start edge, bounded so a stuck busy cannot hang the run
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            cyc();
        end
    endtask

    // Pop the oldest expectation and compare against the committed HI/LO
    task automatic check_commit(input int busy_cycles);
        exp_t e;
        n_checks++;
        assert (sb_q.size() > 0) begin
            n_pass++;
        end else begin
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, "_busy"}, 32'(busy_cycles), 32'(e.cycles));
            chk({e.tag, "_hi"}, HI, e.hi);
            chk({e.tag, "_lo"}, LO, e.lo);
        end
    endtask

    // Launch one operation, scramble the operands during RUN, then check latency and result
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int ncyc);
        exp_t e;
        int   n;
        e.hi = eh; e.lo = el; e.cycles = ncyc; e.tag = tag;
        sb_q.push_back(e);
        SRCA = a; SRCB = b; MDUop = op; start = 1'b1;
        cyc();
        start = 1'b0; MDUop = MDU_NONE;
        SRCA = 32'h5A5A_1234; SRCB = 32'h0000_0007;
        count_busy(n);
        check_commit(n);
    endtask

    initial begin
        int n;
        reset = 1'b0; SRCA = 32'd0; SRCB = 32'd0; MDUop = MDU_NONE; start = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        MDUop = MDU_MFHI; #1;
        chk("reset_mfhi", MDUresult, 32'd0);
        MDUop = MDU_NONE;
        cyc();
        reset = 1'b1;
        cyc();

        // Back-to-back launches: each run_op starts in the first idle cycle
        run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("div_7_m2", MDU_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);

        // mthi/mtlo need no start pulse
        MDUop = MDU_MTHI; SRCA = 32'h0000_1234; cyc();
        MDUop = MDU_MTLO; SRCA = 32'h0000_1234; cyc();
        MDUop = MDU_NONE;
        chk("mthi_hi", HI, 32'h0000_1234);
        chk("mtlo_lo", LO, 32'h0000_1234);
        run_op("divu_by0", MDU_DIVU, 32'd7, 32'd0, 32'h0000_1234, 32'h0000_1234, 10);
        run_op("div_by0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 32'h0000_1234, 32'h0000_1234, 10);

        // mthi then mfhi in the following cycle
        MDUop = MDU_MTHI; SRCA = 32'hAAAA_0000; cyc();
        MDUop = MDU_MFHI; #1;
        chk("mfhi_after_mthi", MDUresult, 32'hAAAA_0000);
        MDUop = MDU_MFLO; #1;
        chk("mflo", MDUresult, 32'h0000_1234);
        MDUop = MDU_NONE; #1;
        chk("none_result", MDUresult, 32'd0);

        // Second start and an mthi while busy are both ignored
        begin
            exp_t e;
            e.hi = 32'd0; e.lo = 32'd12; e.cycles = 5; e.tag = "mult_restart";
            sb_q.push_back(e);
            SRCA = 32'd3; SRCB = 32'd4; MDUop = MDU_MULT; start = 1'b1;
            cyc();
            start = 1'b0; MDUop = MDU_NONE; cyc();
            n = 1;
            SRCA = 32'd9; SRCB = 32'd9; MDUop = MDU_DIV; start = 1'b1; cyc(); n++;
            start = 1'b0; MDUop = MDU_MTHI; SRCA = 32'hDEAD_BEEF; cyc(); n++;
            MDUop = MDU_NONE;
            chk("mthi_while_busy", HI, 32'hAAAA_0000);
            begin
                int rest;
                count_busy(rest);
                check_commit(n + rest);
            end
        end

        // Unqualified start with a non-launch opcode does nothing
        MDUop = MDU_MFHI; start = 1'b1; cyc();
        start = 1'b0; MDUop = MDU_NONE;
        chk("start_bad_op_busy", 32'(busy), 32'd0);

        // Reset in the middle of a divide
        SRCA = 32'd100; SRCB = 32'd3; MDUop = MDU_DIV; start = 1'b1; cyc();
        start = 1'b0; MDUop = MDU_NONE;
        cyc(); cyc();
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        run_op("mult_after_rst", MDU_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
